// File: rtl/rng_arb_pkg.sv
// Shared types and sizing helpers for the rng arbiter.
package rng_arb_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned W_DEF    = 32;
    localparam int unsigned PTR_W    = $clog2(NREQ_DEF);
    localparam int unsigned CNT_W    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        REFILL = 2'd2
    } arb_state_e;

    // Pointer/index width for a given requester count, never zero.
    function automatic int unsigned ptr_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rng_arbiter_if.sv
// Requester-side and rng-side signals of the arbiter, bundled.
interface rng_arbiter_if
    import rng_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32
);
    localparam int unsigned PW = ptr_width(NREQ);

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  ack;
    logic [W-1:0]     rand_out;
    logic [PW-1:0]    gnt_id;
    logic             rng_start;
    logic             rng_valid;
    logic [W-1:0]     rng_data;
    logic             word_ready;
    logic [CNT_W-1:0] served_cnt;

    modport slave (
        input  req, rng_valid, rng_data,
        output ack, rand_out, gnt_id, rng_start, word_ready, served_cnt
    );

    modport master (
        output req, rng_valid, rng_data,
        input  ack, rand_out, gnt_id, rng_start, word_ready, served_cnt
    );
endinterface

// File: rtl/rng_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate by ptr, take lowest set bit, rotate back.
module rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   winner,
    output logic [NREQ-1:0] grant
);
    logic [NREQ-1:0] rot;
    logic [PW-1:0]   off;

    function automatic int wrap(int v);
        return (v >= int'(NREQ)) ? v - int'(NREQ) : v;
    endfunction

    always_comb begin
        rot    = '0;
        off    = '0;
        winner = '0;
        grant  = '0;
        any    = |req;
        for (int i = 0; i < int'(NREQ); i++) begin
            rot[i] = req[wrap(int'(ptr) + i)];
        end
        // Scan downward so the lowest set bit is the one left standing.
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = PW'(i);
            end
        end
        winner = PW'(wrap(int'(off) + int'(ptr)));
        if (any) begin
            grant[winner] = 1'b1;
        end
    end
endmodule

// File: rtl/rng_arbiter.sv
// Hands each rng word to exactly one requester, round-robin, and requests the next word.
module rng_arbiter
    import rng_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    rng_arbiter_if.slave bus
);
    localparam int unsigned PW = ptr_width(NREQ);

    arb_state_e       state_q, state_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [W-1:0]     rand_q, rand_d;
    logic [PW-1:0]    gnt_q, gnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             pick_any;
    logic [PW-1:0]    pick_idx;
    logic [NREQ-1:0]  pick_gnt;

    rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_idx),
        .grant  (pick_gnt)
    );

    // Grant only from IDLE; DRAIN/REFILL ensure the next grant uses a fresh word.
    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        start_d = 1'b0;
        rand_d  = rand_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.rng_valid && pick_any) begin
                    ack_d   = pick_gnt;
                    rand_d  = bus.rng_data;
                    gnt_d   = pick_idx;
                    start_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    ptr_d   = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.rng_valid) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (bus.rng_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= '0;
            rand_q  <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            start_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rand_q  <= rand_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.rand_out   = rand_q;
    assign bus.gnt_id     = gnt_q;
    assign bus.rng_start  = start_q;
    assign bus.served_cnt = cnt_q;
    assign bus.word_ready = (state_q == IDLE) && bus.rng_valid;
endmodule

// File: tb/tb_rng_arbiter.sv
// Randomized bench for rng_arbiter with a stub rng and a transaction-level reference model.
module tb_rng_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rng_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();
    rng_arbiter #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a fresh word may be granted once; after a grant the
    // generator must be seen dropping valid and raising it again, and the new
    // word becomes grantable from the edge after it reappears.
    bit              m_fresh, m_saw_low;
    int              m_ptr, m_gnt;
    logic [NREQ-1:0] m_ack;
    logic [31:0]     m_rand, m_cnt;
    bit              m_start;
    bit              consec;
    logic [31:0]     last_word;

    // Stub rng state
    bit          stub_auto;
    bit          st_busy;
    int          st_hold, st_low;
    logic [31:0] st_word;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    endtask

    function automatic int rr_pick(logic [NREQ-1:0] r, int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_fresh = 1; m_saw_low = 0; m_ptr = 0; m_gnt = 0;
        m_ack = '0; m_rand = '0; m_cnt = '0; m_start = 0;
    endtask

    task automatic model_edge();
        int w;
        m_ack = '0; m_start = 0;
        if (rst) begin model_reset(); return; end
        if (m_fresh) begin
            if (bus.rng_valid && bus.req != '0) begin
                w = rr_pick(bus.req, m_ptr);
                m_ack[w] = 1'b1; m_rand = bus.rng_data; m_gnt = w; m_start = 1;
                m_cnt = m_cnt + 32'd1; m_ptr = (w + 1) % NREQ;
                m_fresh = 0; m_saw_low = 0;
            end
        end else if (!m_saw_low) begin
            if (!bus.rng_valid) m_saw_low = 1;
        end else if (bus.rng_valid) begin
            m_fresh = 1;
        end
    endtask

    task automatic compare();
        chk("ack",        64'(bus.ack),        64'(m_ack));
        chk("rand_out",   64'(bus.rand_out),   64'(m_rand));
        chk("gnt_id",     64'(bus.gnt_id),     64'(m_gnt));
        chk("rng_start",  64'(bus.rng_start),  64'(m_start));
        chk("served_cnt", 64'(bus.served_cnt), 64'(m_cnt));
        chk("word_ready", 64'(bus.word_ready), 64'(m_fresh && bus.rng_valid));
        if (consec && m_start) begin
            chk("word_seq", 64'(bus.rand_out), 64'(last_word + 32'd1));
            last_word = m_rand;
        end
    endtask

    task automatic stub_restart();
        st_busy = 1; st_hold = 0; st_low = $urandom_range(1, 3);
    endtask

    // Auto stub: after start, hold valid 0..2 cycles, drop it, then present the next word.
    task automatic stub_tick();
        if (!stub_auto) return;
        if (bus.rng_start) begin
            st_busy = 1; st_hold = $urandom_range(0, 2); st_low = $urandom_range(1, 3);
        end
        if (st_busy) begin
            if (st_hold > 0) st_hold--;
            else begin
                bus.rng_valid = 1'b0;
                if (st_low > 0) st_low--;
                else begin
                    st_word = st_word + 32'd1;
                    bus.rng_data = st_word; bus.rng_valid = 1'b1; st_busy = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        @(negedge clk);
        stub_tick();
    endtask

    task automatic wait_ack(output int id, output logic [31:0] word, input int budget);
        id = -1; word = '0;
        for (int c = 0; c < budget; c++) begin
            step();
            if (bus.ack != '0) begin
                for (int i = 0; i < NREQ; i++) if (bus.ack[i]) id = i;
                word = bus.rand_out;
                return;
            end
        end
        n_checks++;
        $display("FAIL ack_timeout: actual=no ack required=ack within %0d cycles t=%0t", budget, $time);
    endtask

    task automatic async_reset_check();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_ack",   64'(bus.ack),        64'(0));
        chk("rst_start", 64'(bus.rng_start),  64'(0));
        chk("rst_cnt",   64'(bus.served_cnt), 64'(0));
        chk("rst_rand",  64'(bus.rand_out),   64'(0));
        chk("rst_gnt",   64'(bus.gnt_id),     64'(0));
    endtask

    initial begin
        int id;
        logic [31:0] word;
        int exp_ids [6] = '{0, 1, 2, 3, 0, 1};

        rst = 1'b1; bus.req = 4'b1111; bus.rng_valid = 1'b0; bus.rng_data = '0;
        stub_auto = 0; st_busy = 0; st_word = '0; consec = 0; last_word = '0;
        model_reset();

        // Reset held 101 ns with all requests asserted and no word available
        repeat (10) step();
        chk("rst_hold_cnt", 64'(bus.served_cnt), 64'(0));
        #1 rst = 1'b0;
        repeat (3) begin
            step();
            chk("no_ack_wo_valid", 64'(bus.ack), 64'(0));
        end

        // First word delivered one edge after valid
        bus.req = 4'b0001; bus.rng_valid = 1'b1; bus.rng_data = 32'hDEADBEEF;
        step();
        chk("t2_ack",   64'(bus.ack),        64'(4'b0001));
        chk("t2_rand",  64'(bus.rand_out),   64'(32'hDEADBEEF));
        chk("t2_gnt",   64'(bus.gnt_id),     64'(0));
        chk("t2_start", 64'(bus.rng_start),  64'(1));
        chk("t2_cnt",   64'(bus.served_cnt), 64'(1));
        step();
        chk("t2_start_pulse", 64'(bus.rng_start), 64'(0));
        chk("t2_ack_pulse",   64'(bus.ack),       64'(0));

        // Round-robin order over all four ports with consecutive stub words
        async_reset_check();
        bus.rng_valid = 1'b0; bus.req = 4'b1111;
        stub_auto = 1; st_word = 32'h0FF; stub_restart();
        consec = 1; last_word = 32'h0FF;
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_ack(id, word, 40);
            chk("t3_order", 64'(id), 64'(exp_ids[k]));
            chk("t3_word",  64'(word), 64'(32'h100 + k));
        end
        chk("t3_cnt", 64'(bus.served_cnt), 64'(6));

        // Pointer at 2: port 2 beats port 0
        bus.req = 4'b0101;
        wait_ack(id, word, 40);
        chk("t4_first", 64'(id), 64'(2));
        bus.req = 4'b0001;
        wait_ack(id, word, 40);
        chk("t4_second", 64'(id), 64'(0));

        // Withdrawn request leaves no trace; pointer stays at 1
        stub_auto = 0; consec = 0; bus.rng_valid = 1'b0;
        step(); step();
        bus.req = 4'b0010; step();
        bus.req = 4'b0000; step();
        bus.rng_valid = 1'b1; bus.rng_data = 32'hCAFE0001;
        step(); step();
        chk("t4_no_ack", 64'(bus.ack), 64'(0));
        chk("t4_ready",  64'(bus.word_ready), 64'(1));
        bus.req = 4'b1111;
        step();
        chk("t4_ptr_kept", 64'(bus.ack), 64'(4'b0010));
        chk("t4_gnt",      64'(bus.gnt_id), 64'(1));

        // Reset during DRAIN with valid still high, then immediate re-grant
        async_reset_check();
        bus.req = 4'b0100;
        step();
        rst = 1'b0;
        step();
        chk("t5_ack", 64'(bus.ack),    64'(4'b0100));
        chk("t5_gnt", 64'(bus.gnt_id), 64'(2));

        // MT19937 (seed 5489) first two words presented by the stub
        async_reset_check();
        bus.rng_valid = 1'b0; bus.req = 4'b0011;
        step();
        rst = 1'b0;
        bus.rng_valid = 1'b1; bus.rng_data = 32'd3499211612;
        step();
        chk("t6_ack0",  64'(bus.ack),      64'(4'b0001));
        chk("t6_word0", 64'(bus.rand_out), 64'(32'd3499211612));
        bus.rng_valid = 1'b0;
        step();
        bus.rng_valid = 1'b1; bus.rng_data = 32'd581869302;
        wait_ack(id, word, 6);
        chk("t6_id1",   64'(id),   64'(1));
        chk("t6_word1", 64'(word), 64'(32'd581869302));

        // Random traffic with occasional resets
        async_reset_check();
        bus.rng_valid = 1'b0;
        stub_auto = 1; stub_restart(); consec = 1; last_word = st_word;
        step();
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack[i])     bus.req[i] = 1'($urandom_range(0, 1));
                else if (bus.req[i]) bus.req[i] = ($urandom_range(0, 9) != 0);
                else                bus.req[i] = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 399) == 0) begin
                async_reset_check();
                bus.rng_valid = 1'b0; stub_restart(); last_word = st_word;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
- Shares one Mersenne-twister `rng` instance (ports start/valid/rand_out) among NREQ requesters.
- Watches `rng_valid`. When a word is available and any requester is asking, picks a winner round-robin and hands it the word with a one-cycle ack.
- In the same cycle it pulses `rng_start` so the generator produces the next word.
- Sits between the `rng` core and the consumers (noise sources, test-pattern generators).

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 32, random word width; must equal the rng output width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until matching ack; may be withdrawn at any time.
- ack  out  NREQ  one-hot, one-cycle pulse; rand_out is valid in that cycle.
- rand_out  out  W  word delivered to the acked requester; holds its value until the next ack.
- gnt_id  out  $clog2(NREQ)  index of the last acked requester.
- rng_start  out  1  one-cycle pulse to rng.start; requests the next word.
- rng_valid  in  1  rng.valid; a level meaning "current word available".
- rng_data  in  W  rng.rand_out.
- word_ready  out  1  high in IDLE while rng_valid=1; high means a request is served next edge.
- served_cnt  out  32  count of words delivered; wraps at 2^32.

Behaviour:
- Reset (async; all state cleared immediately):
  - ack=0, rng_start=0, rand_out=0, gnt_id=0, served_cnt=0.
  - Round-robin pointer ptr=0, state=IDLE.
- State IDLE:
  - If rng_valid=1 and req!=0 at a rising edge, register all of: ack[w]=1, rand_out=rng_data, gnt_id=w, rng_start=1, served_cnt+1, ptr=(w+1) mod NREQ. Then go to DRAIN.
  - Otherwise stay in IDLE with ack=0 and rng_start=0.
- Latency: request to ack is 1 cycle when rng_valid is already high.
- State DRAIN:
  - ack and rng_start return to 0 (both are exactly one-cycle pulses).
  - Wait for rng_valid=0, then go to REFILL. This covers an rng that keeps valid high for several cycles after start.
- State REFILL: wait for rng_valid=1, then go to IDLE.
  - No grant is made here, so the fresh word is seen in IDLE one cycle later.
- Winner selection: first set bit of req, searching ptr, ptr+1, ... wrapping modulo NREQ.
- Fairness: any continuously requesting port is served within NREQ grants.
- Request lifetime:
  - req dropped before ack: no grant, no state change.
  - req still high in the cycle after ack: treated as a new request.
- Word use: each rng word goes to exactly one requester; words are never duplicated and never dropped while a request is pending.
- Simultaneous requests: exactly one ack per grant; all other requests wait.
- Reset mid-operation (any state): outputs return to reset values. After reset is released, the block waits in IDLE for rng_valid; the rng re-initialises from its own reset.
- served_cnt: free-running increment, wraps 0xFFFFFFFF to 0.

Decomposition:
- Package rng_arb_pkg:
  - State enum IDLE/DRAIN/REFILL (2-bit encoding).
  - Localparam for ptr width = $clog2(NREQ).
- Sub-module rr_picker (combinational):
  - Inputs: req, ptr.
  - Outputs: any, winner index, one-hot grant.
  - Implementation: rotate, priority-encode, unrotate.
- Top level holds the FSM, output registers and counter.

Test Plan:
1. rst=1 for 101 ns with req=4'b1111, rng_valid=0 -> ack=0, rng_start=0, served_cnt=0 throughout; after release, no ack until rng_valid rises.
2. req=4'b0001; stub rng raises valid with 0xDEADBEEF -> next edge ack=4'b0001, rand_out=0xDEADBEEF, gnt_id=0, rng_start high exactly one cycle, served_cnt=1, state DRAIN.
3. req=4'b1111 held; stub answers start after 3 cycles with an incrementing counter -> grant order 0,1,2,3,0,1. Words are consecutive stub values, each delivered once; served_cnt=6.
4. After a grant to port 1 (ptr=2): req=4'b0101 -> port 2 acked first, then port 0. Then req=4'b0010 withdrawn before rng_valid -> no ack, ptr unchanged.
5. Assert rst in DRAIN while rng_valid=1 -> outputs reset immediately. After release with rng_valid=1 and req=4'b0100 -> ack[2] on the next edge, gnt_id=2.
6. Real rng with SEED=5489, req=4'b0011 -> first acked words to port 0 then port 1 are 3499211612, then 581869302.
